// File: rtl/gru_gate_linear_sched.sv
// GRU gate pass sequencer for the shared recurrent linear unit.
// Runs z/r/h passes in order and streams tagged results out.
module gru_gate_linear_sched #(
    parameter int TIMEOUT = 64,
    parameter int N_ELEM  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    gate_mask,
    input  logic [1023:0] vec_in,
    input  logic          err_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          lin_valid,
    output logic [6:0]    lin_addr_base,
    output logic [1023:0] lin_din,
    input  logic          lin_ready,
    input  logic          lin_done,
    input  logic [31:0]   lin_dout,
    output logic          res_we,
    output logic [1:0]    res_gate,
    output logic [4:0]    res_idx,
    output logic [31:0]   res_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_NEXT    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [4:0] CNT_LAST = 5'(N_ELEM - 1);

    logic [2:0]      state;
    logic [2:0]      pend;
    logic [1:0]      gate;
    logic [4:0]      elem_cnt;
    logic [WD_W-1:0] wd;
    logic            wd_expire;
    logic            cnt_last;

    // Lowest pending gate wins, giving the fixed z, r, h order.
    function automatic logic [1:0] lowest(input logic [2:0] m);
        logic [1:0] g;
        g = 2'd0;
        if (m[0])
            g = 2'd0;
        else if (m[1])
            g = 2'd1;
        else if (m[2])
            g = 2'd2;
        return g;
    endfunction

    // The start pulse is granted the same cycle the unit can take it.
    always_comb begin
        lin_valid = (state == S_ISSUE) && lin_ready;
        wd_expire = (state == S_COLLECT) && !lin_done && (wd == WD_LAST);
        cnt_last  = (elem_cnt == CNT_LAST);
    end

    // Pass sequencing, operand latch and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pend          <= 3'b000;
            gate          <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            lin_addr_base <= 7'd0;
            lin_din       <= '0;
        end else begin
            done <= 1'b0;
            if (err_clr)
                err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (gate_mask != 3'b000) begin
                            lin_din       <= vec_in;
                            pend          <= gate_mask;
                            gate          <= lowest(gate_mask);
                            lin_addr_base <= {lowest(gate_mask), 5'd0};
                            err           <= 1'b0;
                            busy          <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (lin_ready)
                        state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (lin_done) begin
                        if (cnt_last) begin
                            pend  <= pend & ~(3'b001 << gate);
                            state <= S_NEXT;
                        end
                    end else if (wd_expire) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_NEXT: begin
                    if (pend != 3'b000) begin
                        gate          <= lowest(pend);
                        lin_addr_base <= {lowest(pend), 5'd0};
                        state         <= S_ISSUE;
                    end else begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Element counter and stall watchdog, both restarted per pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt <= 5'd0;
            wd       <= '0;
        end else if (state == S_ISSUE) begin
            if (lin_ready) begin
                elem_cnt <= 5'd0;
                wd       <= '0;
            end
        end else if (state == S_COLLECT) begin
            if (lin_done) begin
                wd <= '0;
                if (!cnt_last)
                    elem_cnt <= elem_cnt + 5'd1;
            end else if (!wd_expire) begin
                wd <= wd + 1'b1;
            end
        end
    end

    // Results are registered and tagged with gate and element index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_we   <= 1'b0;
            res_gate <= 2'd0;
            res_idx  <= 5'd0;
            res_data <= 32'd0;
        end else begin
            res_we <= 1'b0;
            if (state == S_COLLECT && lin_done) begin
                res_we   <= 1'b1;
                res_gate <= gate;
                res_idx  <= elem_cnt;
                res_data <= lin_dout;
            end
        end
    end

endmodule

// File: tb/tb_gru_gate_linear_sched.sv
// Directed bench for gru_gate_linear_sched with a small
// linear-unit model answering 4 cycles after each start pulse.
module tb_gru_gate_linear_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    gate_mask;
    logic [1023:0] vec_in;
    logic          err_clr;
    logic          busy, done, err, lin_valid;
    logic [6:0]    lin_addr_base;
    logic [1023:0] lin_din;
    logic          lin_ready;
    logic          lin_done;
    logic [31:0]   lin_dout;
    logic          res_we;
    logic [1:0]    res_gate;
    logic [4:0]    res_idx;
    logic [31:0]   res_data;

    logic          m_done = 1'b0;
    logic          s_done = 1'b0;
    logic [31:0]   m_dout = 32'd0;
    logic [1:0]    m_g = 2'd0;
    bit            stop_r = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_we = 0;
    int n_done = 0;
    int last_we_cyc = 0;
    int wi = 0;
    logic [1:0] cur_g = 2'd0;
    logic [1023:0] vec_exp = '0;
    logic [1023:0] v1, v2;
    int v0, w0, d0;
    bit ok;

    assign lin_done = m_done | s_done;
    assign lin_dout = m_dout;

    always #5 clk = ~clk;

    gru_gate_linear_sched #(.TIMEOUT(64), .N_ELEM(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .gate_mask(gate_mask),
        .vec_in(vec_in),
        .err_clr(err_clr),
        .busy(busy),
        .done(done),
        .err(err),
        .lin_valid(lin_valid),
        .lin_addr_base(lin_addr_base),
        .lin_din(lin_din),
        .lin_ready(lin_ready),
        .lin_done(lin_done),
        .lin_dout(lin_dout),
        .res_we(res_we),
        .res_gate(res_gate),
        .res_idx(res_idx),
        .res_data(res_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic [6:0] exp_addr, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (lin_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen)
            chk(tag, 64'(lin_addr_base), 64'(exp_addr));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_lat"}, 64'(cyc - last_we_cyc), 64'd2);
            chk({tag, "_busy"}, 64'(busy), 64'd0);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: write stream contents and operand stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (lin_valid) begin
                n_valid++;
                cur_g = lin_addr_base[6:5];
                wi = 0;
            end
            if (res_we) begin
                chk("res_gate", 64'(res_gate), 64'(cur_g));
                chk("res_idx", 64'(res_idx), 64'(wi));
                chk("res_data", 64'(res_data),
                    64'(32'h1000 + 32'(cur_g) * 32'h100 + 32'(wi)));
                wi++;
                n_we++;
                last_we_cyc = cyc;
            end
            if (done)
                n_done++;
            if (busy) begin
                n_cmp++;
                assert (lin_din === vec_exp) else begin
                    n_bad++;
                    $error("FAIL lin_din: observed %0h expected %0h",
                           lin_din[63:0], vec_exp[63:0]);
                end
            end
        end
    end

    // Linear unit model: 32 results starting 4 cycles after lin_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (lin_valid && !rst) begin
                m_g = lin_addr_base[6:5];
                repeat (3) @(posedge clk);
                for (int i = 0; i < 32; i++) begin
                    @(posedge clk);
                    #1;
                    m_done = 1'b0;
                    if (rst || (stop_r && m_g == 2'd1 && i == 10))
                        break;
                    m_done = 1'b1;
                    m_dout = 32'h1000 + 32'(m_g) * 32'h100 + 32'(i);
                end
                @(posedge clk);
                #1;
                m_done = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            v1[i*32 +: 32] = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
            v2[i*32 +: 32] = 32'h3C00_0000 ^ (32'(i) * 32'h0011_2233);
        end
        rst = 1'b1;
        start = 1'b0;
        gate_mask = 3'b000;
        vec_in = '0;
        err_clr = 1'b0;
        lin_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_valid", 64'(lin_valid), 64'd0);
        chk("rst_we", 64'(res_we), 64'd0);
        chk("rst_addr", 64'(lin_addr_base), 64'd0);
        chk("rst_gate", 64'(res_gate), 64'd0);
        chk("rst_idx", 64'(res_idx), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_din", 64'(lin_din == '0), 64'd1);
        step(1);
        rst = 1'b0;
        step(1);

        // Full run with a spurious start mid-run
        v0 = n_valid; w0 = n_we; d0 = n_done;
        vec_exp = v1;
        vec_in = v1;
        gate_mask = 3'b111;
        start = 1'b1;
        @(negedge clk);
        chk("full_busy_pre", 64'(busy), 64'd0);
        step(1);
        start = 1'b0;
        gate_mask = 3'b000;
        @(negedge clk);
        chk("full_valid_c2", 64'(lin_valid), 64'd1);
        chk("full_addr_z", 64'(lin_addr_base), 64'h00);
        chk("full_busy", 64'(busy), 64'd1);
        step(1);
        start = 1'b1;
        gate_mask = 3'b001;
        vec_in = v2;
        step(1);
        start = 1'b0;
        wait_valid(7'h20, "full_addr_r");
        wait_valid(7'h40, "full_addr_h");
        wait_done("full_done");
        step(2);
        chk("full_nvalid", 64'(n_valid - v0), 64'd3);
        chk("full_nwe", 64'(n_we - w0), 64'd96);
        chk("full_ndone", 64'(n_done - d0), 64'd1);

        // Spurious lin_done in IDLE
        w0 = n_we;
        s_done = 1'b1;
        step(3);
        s_done = 1'b0;
        step(2);
        chk("spur_nwe", 64'(n_we - w0), 64'd0);
        chk("spur_busy", 64'(busy), 64'd0);

        // Empty mask
        v0 = n_valid; d0 = n_done;
        gate_mask = 3'b000;
        start = 1'b1;
        @(negedge clk);
        chk("m0_done_pre", 64'(done), 64'd0);
        step(1);
        start = 1'b0;
        @(negedge clk);
        chk("m0_done", 64'(done), 64'd1);
        chk("m0_busy", 64'(busy), 64'd0);
        step(3);
        chk("m0_nvalid", 64'(n_valid - v0), 64'd0);
        chk("m0_ndone", 64'(n_done - d0), 64'd1);
        chk("m0_busy_after", 64'(busy), 64'd0);

        // h gate only
        v0 = n_valid; w0 = n_we;
        vec_in = v2;
        vec_exp = v2;
        gate_mask = 3'b100;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(7'h40, "h_addr");
        wait_done("h_done");
        step(2);
        chk("h_nvalid", 64'(n_valid - v0), 64'd1);
        chk("h_nwe", 64'(n_we - w0), 64'd32);

        // Ready stall
        v0 = n_valid; w0 = n_we;
        lin_ready = 1'b0;
        vec_in = v1;
        vec_exp = v1;
        gate_mask = 3'b001;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(100);
        chk("stall_nvalid", 64'(n_valid - v0), 64'd0);
        chk("stall_err", 64'(err), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        lin_ready = 1'b1;
        @(negedge clk);
        chk("stall_valid", 64'(lin_valid), 64'd1);
        chk("stall_addr", 64'(lin_addr_base), 64'h00);
        wait_done("stall_done");
        step(2);
        chk("stall_nvalid2", 64'(n_valid - v0), 64'd1);
        chk("stall_nwe", 64'(n_we - w0), 64'd32);

        // Watchdog: r stops after 10 results
        v0 = n_valid; w0 = n_we; d0 = n_done;
        stop_r = 1'b1;
        gate_mask = 3'b111;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(7'h00, "wd_addr_z");
        wait_valid(7'h20, "wd_addr_r");
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wd_err_seen", 64'(ok), 64'd1);
        chk("wd_err_lat", 64'(cyc - last_we_cyc), 64'd64);
        chk("wd_busy", 64'(busy), 64'd0);
        step(5);
        chk("wd_nvalid", 64'(n_valid - v0), 64'd2);
        chk("wd_nwe", 64'(n_we - w0), 64'd42);
        chk("wd_ndone", 64'(n_done - d0), 64'd0);
        chk("wd_err_sticky", 64'(err), 64'd1);
        stop_r = 1'b0;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("wd_err_clr", 64'(err), 64'd0);
        step(1);
        w0 = n_we;
        vec_in = v2;
        vec_exp = v2;
        gate_mask = 3'b010;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(7'h20, "wd2_addr_r");
        wait_done("wd2_done");
        step(2);
        chk("wd2_nwe", 64'(n_we - w0), 64'd32);
        chk("wd2_err", 64'(err), 64'd0);

        // Reset mid-run at idx 17 of z
        d0 = n_done;
        vec_in = v1;
        vec_exp = v1;
        gate_mask = 3'b111;
        start = 1'b1;
        step(1);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_we && res_gate == 2'd0 && res_idx == 5'd17) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mr_idx17_seen", 64'(ok), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_we", 64'(res_we), 64'd0);
        chk("mr_idx", 64'(res_idx), 64'd0);
        chk("mr_data", 64'(res_data), 64'd0);
        chk("mr_addr", 64'(lin_addr_base), 64'd0);
        chk("mr_din", 64'(lin_din == '0), 64'd1);
        chk("mr_done", 64'(done), 64'd0);
        step(2);
        rst = 1'b0;
        step(3);
        chk("mr_ndone", 64'(n_done - d0), 64'd0);
        w0 = n_we;
        vec_in = v2;
        vec_exp = v2;
        gate_mask = 3'b111;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(7'h00, "mr2_addr_z");
        wait_valid(7'h20, "mr2_addr_r");
        wait_valid(7'h40, "mr2_addr_h");
        wait_done("mr2_done");
        step(2);
        chk("mr2_nwe", 64'(n_we - w0), 64'd96);
        chk("mr2_ndone", 64'(n_done - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
